npp_flit_tx: RTL and testbench

- Credit-flow-controlled NoC packet-protocol (NPP) flit transmitter; drives the flit/valid/credit_rdy side of an NPP link and consumes credit_return from the receiving NMU/NSU npp_in port.
- Serves behavioural traffic injection in simulation wrappers and PL-side NPP endpoints.
- Accepts flits plus a VC id on a valid/ready source interface, tracks credits per VC, and emits one registered flit per cycle when that VC holds a credit.

---
 rtl/npp_pkg.sv | 16 +
 rtl/npp_credit_counter.sv | 34 +++
 rtl/npp_flit_tx.sv | 138 +++++++++++++
 tb/tb_npp_flit_tx.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/npp_pkg.sv
// Shared NPP types and defaults for the flit transmitter and its credit counters.
package npp_pkg;

  localparam int unsigned NPP_FLIT_W = 182;
  localparam int unsigned NPP_NUM_VC = 8;

  typedef logic [NPP_FLIT_W-1:0]         npp_flit_t;
  typedef logic [$clog2(NPP_NUM_VC)-1:0] npp_vc_t;

  typedef enum logic [1:0] {
    INIT,
    ACTIVE,
    DRAIN
  } npp_tx_state_e;

endpackage

// File: rtl/npp_credit_counter.sv
// Per-VC credit counter: saturates at MAX_CREDITS and flags a return that arrives while full.
module npp_credit_counter #(
  parameter int unsigned  MAX_CREDITS = 8,
  localparam int unsigned CW          = $clog2(MAX_CREDITS + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_inc,
  input  logic          i_dec,
  output logic [CW-1:0] o_count,
  output logic          o_nonzero,
  output logic          o_full,
  output logic          o_overflow
);

  logic [CW-1:0] r_count;

  // A same-cycle inc and dec cancel; the caller never decrements at zero.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_inc && !i_dec && !o_full) begin
      r_count <= r_count + CW'(1);
    end else if (i_dec && !i_inc) begin
      r_count <= r_count - CW'(1);
    end
  end

  assign o_count    = r_count;
  assign o_nonzero  = (r_count != '0);
  assign o_full     = (r_count == CW'(MAX_CREDITS));
  assign o_overflow = i_inc && !i_dec && o_full;

endmodule

// File: rtl/npp_flit_tx.sv
// Credit-flow-controlled NPP flit transmitter with per-VC credit tracking and a drain mode.
// Define NPP_TX_STATS_EN to add per-VC sent-flit and source-stall counters.
module npp_flit_tx
  import npp_pkg::*;
#(
  parameter int unsigned  FLIT_W      = NPP_FLIT_W,
  parameter int unsigned  NUM_VC      = NPP_NUM_VC,
  parameter int unsigned  MAX_CREDITS = 8,
  parameter int unsigned  INIT_CYCLES = 4,
  localparam int unsigned VC_W        = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
  localparam int unsigned CW          = $clog2(MAX_CREDITS + 1),
  localparam int unsigned TW          = $clog2(INIT_CYCLES + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [FLIT_W-1:0]    s_flit,
  input  logic [VC_W-1:0]      s_vc,
  input  logic                 quiesce_req,
  output logic                 quiesced,
  output logic [FLIT_W-1:0]    npp_flit,
  output logic [NUM_VC-1:0]    npp_valid,
  output logic                 npp_credit_rdy,
  input  logic [NUM_VC-1:0]    npp_credit_return,
  output logic [NUM_VC*CW-1:0] credit_avail,
  output logic                 credit_err
`ifdef NPP_TX_STATS_EN
  ,
  output logic [NUM_VC*32-1:0] stat_flits,
  output logic [31:0]          stat_stalls
`endif
);

  npp_tx_state_e     r_state;
  logic [TW-1:0]     r_timer;
  logic              r_credit_rdy;
  logic [NUM_VC-1:0] r_valid;
  logic [FLIT_W-1:0] r_flit;
  logic              r_quiesced;
  logic              r_err;

  logic              w_vc_ok;
  logic [NUM_VC-1:0] w_inc;
  logic [NUM_VC-1:0] w_dec;
  logic [NUM_VC-1:0] w_nonzero;
  logic [NUM_VC-1:0] w_full;
  logic [NUM_VC-1:0] w_ovf;

  assign w_vc_ok = (32'(s_vc) < NUM_VC);
  assign s_ready = (r_state == ACTIVE) && s_valid && w_vc_ok && w_nonzero[s_vc];
  assign w_dec   = s_ready ? (NUM_VC'(1) << s_vc) : '0;
  // Credits returned before the link is up are dropped, not banked.
  assign w_inc   = npp_credit_return & {NUM_VC{r_credit_rdy}};

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    npp_credit_counter #(
      .MAX_CREDITS(MAX_CREDITS)
    ) u_cnt (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_inc      (w_inc[v]),
      .i_dec      (w_dec[v]),
      .o_count    (credit_avail[v*CW +: CW]),
      .o_nonzero  (w_nonzero[v]),
      .o_full     (w_full[v]),
      .o_overflow (w_ovf[v])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= INIT;
      r_timer      <= '0;
      r_credit_rdy <= 1'b0;
      r_valid      <= '0;
      r_flit       <= '0;
      r_quiesced   <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_valid <= w_dec;
      if (s_ready) r_flit <= s_flit;
      if ((|w_ovf) || (s_valid && !w_vc_ok)) r_err <= 1'b1;
      case (r_state)
        INIT: begin
          if (r_timer == TW'(INIT_CYCLES - 1)) begin
            r_state      <= ACTIVE;
            r_credit_rdy <= 1'b1;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        ACTIVE: begin
          r_quiesced <= 1'b0;
          if (quiesce_req) r_state <= DRAIN;
        end
        DRAIN: begin
          if (quiesce_req) begin
            r_quiesced <= &w_full;
          end else begin
            r_state    <= ACTIVE;
            r_quiesced <= 1'b0;
          end
        end
        default: r_state <= INIT;
      endcase
    end
  end

  assign npp_flit       = r_flit;
  assign npp_valid      = r_valid;
  assign npp_credit_rdy = r_credit_rdy;
  assign quiesced       = r_quiesced;
  assign credit_err     = r_err;

`ifdef NPP_TX_STATS_EN
  logic [31:0] r_stat_flits [NUM_VC];
  logic [31:0] r_stat_stalls;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int v = 0; v < NUM_VC; v++) r_stat_flits[v] <= '0;
      r_stat_stalls <= '0;
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        if (w_dec[v] && (r_stat_flits[v] != '1)) r_stat_flits[v] <= r_stat_flits[v] + 32'd1;
      end
      if (s_valid && !s_ready && (r_stat_stalls != '1)) r_stat_stalls <= r_stat_stalls + 32'd1;
    end
  end

  for (genvar v = 0; v < NUM_VC; v++) begin : g_stat
    assign stat_flits[v*32 +: 32] = r_stat_flits[v];
  end
  assign stat_stalls = r_stat_stalls;
`endif

endmodule

// File: tb/tb_npp_flit_tx.sv
// Scoreboard bench for npp_flit_tx: directed scenarios plus randomized traffic vs a credit model.
module tb_npp_flit_tx;
  import npp_pkg::*;

  localparam int unsigned FLIT_W      = NPP_FLIT_W;
  localparam int unsigned NUM_VC      = NPP_NUM_VC;
  localparam int unsigned MAX_CREDITS = 8;
  localparam int unsigned INIT_CYCLES = 4;
  localparam int unsigned CW          = $clog2(MAX_CREDITS + 1);

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 s_valid = 1'b0;
  logic                 s_ready;
  npp_flit_t            s_flit = '0;
  npp_vc_t              s_vc = '0;
  logic                 quiesce_req = 1'b0;
  logic                 quiesced;
  npp_flit_t            npp_flit;
  logic [NUM_VC-1:0]    npp_valid;
  logic                 npp_credit_rdy;
  logic [NUM_VC-1:0]    npp_credit_return = '0;
  logic [NUM_VC*CW-1:0] credit_avail;
  logic                 credit_err;
`ifdef NPP_TX_STATS_EN
  logic [NUM_VC*32-1:0] stat_flits;
  logic [31:0]          stat_stalls;
`endif

  npp_flit_tx #(
    .FLIT_W      (FLIT_W),
    .NUM_VC      (NUM_VC),
    .MAX_CREDITS (MAX_CREDITS),
    .INIT_CYCLES (INIT_CYCLES)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .s_valid           (s_valid),
    .s_ready           (s_ready),
    .s_flit            (s_flit),
    .s_vc              (s_vc),
    .quiesce_req       (quiesce_req),
    .quiesced          (quiesced),
    .npp_flit          (npp_flit),
    .npp_valid         (npp_valid),
    .npp_credit_rdy    (npp_credit_rdy),
    .npp_credit_return (npp_credit_return),
    .credit_avail      (credit_avail),
    .credit_err        (credit_err)
`ifdef NPP_TX_STATS_EN
    ,
    .stat_flits        (stat_flits),
    .stat_stalls       (stat_stalls)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: credits as plain integers, link-up as a cycle count since reset.
  typedef struct {
    int unsigned vc;
    npp_flit_t   flit;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned m_credits [NUM_VC];
  int unsigned m_stat_flits [NUM_VC];
  int unsigned m_stalls;
  int unsigned m_since;
  bit          m_err, m_drain, m_quiesced, m_live;
  int          n_checks = 0;
  int          n_fail = 0;

  function automatic bit m_ready_now();
    return m_live && (m_since >= INIT_CYCLES) && !m_drain && s_valid && (m_credits[s_vc] > 0);
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    bit rdy, acc, all_full, ret, con;
    if (rst) begin
      m_live = 1'b1; m_since = 0; m_err = 1'b0; m_drain = 1'b0; m_quiesced = 1'b0;
      m_stalls = 0;
      exp_q.delete();
      for (int v = 0; v < NUM_VC; v++) begin
        m_credits[v] = 0;
        m_stat_flits[v] = 0;
      end
    end else if (m_live) begin
      rdy = (m_since >= INIT_CYCLES);
      acc = m_ready_now();
      all_full = 1'b1;
      for (int v = 0; v < NUM_VC; v++) if (m_credits[v] != MAX_CREDITS) all_full = 1'b0;
      if (s_valid && !acc) m_stalls++;
      if (acc) begin
        exp_q.push_back('{vc: s_vc, flit: s_flit});
        m_stat_flits[s_vc]++;
      end
      for (int v = 0; v < NUM_VC; v++) begin
        ret = rdy && npp_credit_return[v];
        con = acc && (s_vc == v);
        if (ret && !con) begin
          if (m_credits[v] == MAX_CREDITS) m_err = 1'b1;
          else m_credits[v]++;
        end else if (con && !ret) begin
          m_credits[v]--;
        end
      end
      if (rdy) begin
        m_quiesced = m_drain && quiesce_req && all_full;
        m_drain    = quiesce_req;
      end else begin
        m_since++;
      end
    end
  end

  // Monitor: sample mid-cycle, pop the scoreboard whenever a flit is expected.
  always @(negedge clk) begin
    logic [NUM_VC-1:0]    ev;
    logic [NUM_VC*CW-1:0] eca;
    exp_t                 e;
    #2;
    if (m_live) begin
      ev = '0;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        ev[e.vc] = 1'b1;
        check("npp_flit", 256'(npp_flit), 256'(e.flit));
      end
      check("npp_valid", 256'(npp_valid), 256'(ev));
      for (int v = 0; v < NUM_VC; v++) eca[v*CW +: CW] = CW'(m_credits[v]);
      check("credit_avail", 256'(credit_avail), 256'(eca));
      check("npp_credit_rdy", 256'(npp_credit_rdy), 256'(m_since >= INIT_CYCLES));
      check("credit_err", 256'(credit_err), 256'(m_err));
      check("quiesced", 256'(quiesced), 256'(m_quiesced));
      check("s_ready", 256'(s_ready), 256'(m_ready_now()));
`ifdef NPP_TX_STATS_EN
      for (int v = 0; v < NUM_VC; v++) check("stat_flits", 256'(stat_flits[v*32 +: 32]), 256'(m_stat_flits[v]));
      check("stat_stalls", 256'(stat_stalls), 256'(m_stalls));
`endif
    end
  end

  function automatic npp_flit_t rnd_flit();
    logic [191:0] w;
    for (int i = 0; i < 6; i++) w[i*32 +: 32] = $urandom;
    return w[FLIT_W-1:0];
  endfunction

  // One cycle of stimulus, applied at the falling edge; acc reports a handshake at the next rise.
  task automatic step(input logic v, input npp_vc_t vc, input npp_flit_t f,
                      input logic [NUM_VC-1:0] ret, output logic acc);
    s_valid = v; s_vc = vc; s_flit = f; npp_credit_return = ret;
    #4 acc = s_ready;
    @(negedge clk);
  endtask

  task automatic send(input npp_vc_t vc, input npp_flit_t f);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < 16 && !acc; i++) step(1'b1, vc, f, '0, acc);
    n_checks++;
    if (!acc) begin
      n_fail++;
      $display("FAIL send_accept: vc %0d got no handshake in 16 cycles, expected one", vc);
    end
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, acc);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic              acc, hvld;
    npp_flit_t         f;
    npp_vc_t           hv;
    logic [NUM_VC-1:0] r;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    // Link-up: returns during the init window must be dropped; no credits means no accept.
    f = rnd_flit();
    for (int i = 0; i < 4; i++) step(1'b1, npp_vc_t'(2), f, NUM_VC'($urandom), acc);
    for (int i = 0; i < 3; i++) step(1'b1, npp_vc_t'(2), f, '0, acc);

    // Eight credits on VC3, then a stream of ten flits.
    for (int i = 0; i < 8; i++) step(1'b0, '0, '0, 8'h08, acc);
    for (int i = 0; i < 8; i++) send(npp_vc_t'(3), rnd_flit());
    f = rnd_flit();
    for (int i = 0; i < 3; i++) step(1'b1, npp_vc_t'(3), f, '0, acc);
    step(1'b1, npp_vc_t'(3), f, 8'h08, acc);
    send(npp_vc_t'(3), f);
    step(1'b0, '0, '0, 8'h08, acc);
    send(npp_vc_t'(3), rnd_flit());

    // Same-cycle return and consume on VC0 at count 1.
    step(1'b0, '0, '0, 8'h01, acc);
    step(1'b1, npp_vc_t'(0), rnd_flit(), 8'h01, acc);
    idle(1);

    // Nine returns on VC5: the ninth overflows and latches credit_err.
    for (int i = 0; i < 9; i++) step(1'b0, '0, '0, 8'h20, acc);
    idle(3);

    // Fill every VC to full except VC1 at 6, then drain.
    for (int i = 0; i < 20; i++) begin
      for (int v = 0; v < NUM_VC; v++) r[v] = (m_credits[v] < ((v == 1) ? 6 : MAX_CREDITS));
      if (r == '0) break;
      step(1'b0, '0, '0, r, acc);
    end
    quiesce_req = 1'b1;
    idle(1);
    f = rnd_flit();
    step(1'b1, npp_vc_t'(1), f, '0, acc);
    step(1'b1, npp_vc_t'(1), f, 8'h02, acc);
    step(1'b1, npp_vc_t'(1), f, 8'h02, acc);
    step(1'b1, npp_vc_t'(1), f, '0, acc);
    step(1'b1, npp_vc_t'(1), f, '0, acc);
    quiesce_req = 1'b0;
    send(npp_vc_t'(1), f);

    // Randomized traffic with occasional quiesce toggles; sources hold until accepted.
    hvld = 1'b0; acc = 1'b1; hv = '0; f = '0;
    for (int i = 0; i < 400; i++) begin
      if (!hvld || acc) begin
        hvld = ($urandom_range(0, 3) != 0);
        hv   = npp_vc_t'($urandom_range(0, NUM_VC - 1));
        f    = rnd_flit();
      end
      for (int v = 0; v < NUM_VC; v++)
        r[v] = (m_credits[v] < MAX_CREDITS) && ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 31) == 0) quiesce_req = ~quiesce_req;
      step(hvld, hv, f, r, acc);
    end
    quiesce_req = 1'b0;
    idle(3);

    // Reset while a VC0 flit is on the link.
    if (m_credits[0] == 0) step(1'b0, '0, '0, 8'h01, acc);
    send(npp_vc_t'(0), rnd_flit());
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(8);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
